// File: rtl/uart_tx_fifo_ctrl_if.sv
// Handshake bundle between the TX word FIFO, the byte transmitter core and
// the sequencer that sits between them. The master modport is the sequencer.
interface uart_tx_fifo_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd_en;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             ctrl_busy;
  logic [15:0]      word_cnt;

  modport master (
    input  en, fifo_empty, fifo_dout, tx_busy,
    output fifo_rd_en, tx_start, tx_data, ctrl_busy, word_cnt
  );

  modport slave (
    output en, fifo_empty, fifo_dout, tx_busy,
    input  fifo_rd_en, tx_start, tx_data, ctrl_busy, word_cnt
  );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// UART TX sequencer: pops one WIDTH-bit word from the FIFO and sends it as
// WIDTH/8 bytes through the transmitter start/busy handshake, with an optional
// idle gap after each byte and a count of completed words.
// Optional feature: define UART_TX_CTRL_CHKSUM_EN to append an XOR checksum
// byte after every BLK_WORDS-th word.
module uart_tx_fifo_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned BLK_WORDS  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_tx_fifo_ctrl_if.master  bus
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);
  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if ((WIDTH == 0) || ((WIDTH % 8) != 0)) begin : g_width_chk
    $error("WIDTH must be a nonzero multiple of 8");
  end
  if (GAP_CYCLES > 255) begin : g_gap_chk
    $error("GAP_CYCLES must be in 0..255");
  end
  if (BLK_WORDS == 0) begin : g_blk_chk
    $error("BLK_WORDS must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StSend,
    StWait,
    StGap
`ifdef UART_TX_CTRL_CHKSUM_EN
    , StChk
`endif
  } state_e;

  state_e           state_q;
  logic             rd_en_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic [15:0]      word_cnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [7:0]       gap_q;
  logic [WIDTH-1:0] shift_q;
  logic             wait_first_q;

`ifdef UART_TX_CTRL_CHKSUM_EN
  localparam int unsigned BlkW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLK_WORDS - 1);
  logic [7:0]      acc_q;
  logic [BlkW-1:0] blk_q;
  logic            chk_q;  // the byte in flight is the checksum byte
`endif

  logic [7:0] cur_byte;
  logic       byte_done;

  // Current byte from the shift register and the "byte fully finished" condition.
  always_comb begin
    cur_byte  = LSB_FIRST ? shift_q[7:0] : shift_q[WIDTH-1 -: 8];
    byte_done = ((state_q == StWait) && !wait_first_q && !bus.tx_busy && (GAP_CYCLES == 0))
              || ((state_q == StGap) && (gap_q == 8'd0));
  end

  // Sequencer FSM with registered strobes and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_en_q      <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      word_cnt_q   <= 16'd0;
      idx_q        <= '0;
      gap_q        <= 8'd0;
      shift_q      <= '0;
      wait_first_q <= 1'b0;
`ifdef UART_TX_CTRL_CHKSUM_EN
      acc_q        <= 8'd0;
      blk_q        <= '0;
      chk_q        <= 1'b0;
`endif
    end else begin
      rd_en_q    <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.en && !bus.fifo_empty) begin
            rd_en_q <= 1'b1;
            state_q <= StRead;
          end
        end
        StRead: state_q <= StLoad;
        StLoad: begin
          shift_q <= bus.fifo_dout;
          idx_q   <= '0;
          state_q <= StSend;
        end
        StSend: begin
          if (!bus.tx_busy) begin
            tx_data_q    <= cur_byte;
            tx_start_q   <= 1'b1;
            shift_q      <= LSB_FIRST ? (shift_q >> 8) : (shift_q << 8);
            wait_first_q <= 1'b1;
            state_q      <= StWait;
`ifdef UART_TX_CTRL_CHKSUM_EN
            acc_q        <= acc_q ^ cur_byte;
`endif
          end
        end
        StWait: begin
          // First WAIT clock covers the transmitter's start-to-busy latency.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!bus.tx_busy && (GAP_CYCLES != 0)) begin
            gap_q   <= GapLoad;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (gap_q != 8'd0) gap_q <= gap_q - 8'd1;
        end
`ifdef UART_TX_CTRL_CHKSUM_EN
        StChk: begin
          if (!bus.tx_busy) begin
            tx_data_q    <= acc_q;
            tx_start_q   <= 1'b1;
            wait_first_q <= 1'b1;
            chk_q        <= 1'b1;
            state_q      <= StWait;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase

      // Next-byte / end-of-word handling once a byte (and its gap) is done.
      if (byte_done) begin
`ifdef UART_TX_CTRL_CHKSUM_EN
        if (chk_q) begin
          chk_q   <= 1'b0;
          acc_q   <= 8'd0;
          blk_q   <= '0;
          state_q <= StIdle;
        end else
`endif
        if (idx_q != LastIdx) begin
          idx_q   <= idx_q + 1'b1;
          state_q <= StSend;
        end else begin
          word_cnt_q <= word_cnt_q + 16'd1;
`ifdef UART_TX_CTRL_CHKSUM_EN
          if (blk_q == BlkLast) begin
            state_q <= StChk;
          end else begin
            blk_q   <= blk_q + 1'b1;
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.word_cnt   = word_cnt_q;
  assign bus.ctrl_busy  = (state_q != StIdle);

endmodule
